pipelined_add_sub: RTL and testbench



---
 rtl/pipelined_add_sub.sv | 105 ++++++++++
 tb/tb_pipelined_add_sub.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit add/subtract with the carry chain cut
// into STAGES equal chunks, one chunk resolved per clock.
// Ports: clk, rst (sync, active-high)
//        in_valid/in_ready, a, b, c_in, sub  (operand side)
//        out_valid/out_ready, sum, c_out, ovf (result side)
module pipelined_add_sub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);
   localparam int CHUNK = WIDTH / STAGES;

   // word_q[k]: finished sum bits below chunk k+1,
   // still-unconsumed a bits above it.
   logic [WIDTH-1:0]  word_q [STAGES];
   logic [WIDTH-1:0]  beff_q [STAGES];
   logic [STAGES-1:0] cy_q;
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] amsb_q;
   logic              adv;

   assign out_valid = vld_q[STAGES-1];
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] w_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] w_nxt;
      logic [CHUNK:0]   part;
      logic             c_i;
      logic             v_i;
      logic             m_i;
      logic [WIDTH-1:0] w_q;
      logic [WIDTH-1:0] b_q;
      logic             c_q;
      logic             v_q;
      logic             m_q;

      if (k == 0) begin : g_head
         // subtract is a + ~b + ~c_in
         assign w_in = a;
         assign b_in = sub ? ~b : b;
         assign c_i  = sub ? ~c_in : c_in;
         assign v_i  = in_valid;
         assign m_i  = a[WIDTH-1];
      end else begin : g_body
         assign w_in = word_q[k-1];
         assign b_in = beff_q[k-1];
         assign c_i  = cy_q[k-1];
         assign v_i  = vld_q[k-1];
         assign m_i  = amsb_q[k-1];
      end

      always_comb begin
         part  = {1'b0, w_in[k*CHUNK +: CHUNK]}
               + {1'b0, b_in[k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, c_i};
         w_nxt = w_in;
         w_nxt[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            w_q <= '0;
            b_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
            m_q <= 1'b0;
         end else if (adv) begin
            w_q <= w_nxt;
            b_q <= b_in;
            c_q <= part[CHUNK];
            v_q <= v_i;
            m_q <= m_i;
         end
      end

      assign word_q[k] = w_q;
      assign beff_q[k] = b_q;
      assign cy_q[k]   = c_q;
      assign vld_q[k]  = v_q;
      assign amsb_q[k] = m_q;
   end

   assign sum   = word_q[STAGES-1];
   assign c_out = cy_q[STAGES-1];
   // b_eff msb rides along in the last skew register
   assign ovf   = (amsb_q[STAGES-1] == beff_q[STAGES-1][WIDTH-1])
               && (sum[WIDTH-1] != amsb_q[STAGES-1]);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed and random checks of pipelined_add_sub
// for WIDTH=32/STAGES=4 and WIDTH=8/STAGES=1.
module tb_pipelined_add_sub;
   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        o;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        iv = 1'b0, ci = 1'b0, sb = 1'b0, ordy = 1'b1;
   logic        ir, ov, co, of;
   logic [31:0] a = '0, b = '0, s;

   logic        x_iv = 1'b0, x_ci = 1'b0, x_sb = 1'b0, x_ordy = 1'b1;
   logic        x_ir, x_ov, x_co, x_of;
   logic [7:0]  x_a = '0, x_b = '0, x_s;

   pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(iv), .in_ready(ir),
      .a(a), .b(b), .c_in(ci), .sub(sb),
      .out_valid(ov), .out_ready(ordy),
      .sum(s), .c_out(co), .ovf(of)
   );

   pipelined_add_sub #(.WIDTH(8), .STAGES(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(x_iv), .in_ready(x_ir),
      .a(x_a), .b(x_b), .c_in(x_ci), .sub(x_sb),
      .out_valid(x_ov), .out_ready(x_ordy),
      .sum(x_s), .c_out(x_co), .ovf(x_of)
   );

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          lat_on = 1'b0;
   res_t        q0 [$];
   int          t0q [$];
   res_t        q1 [$];
   int          t1q [$];
   bit          hold0 = 1'b0;
   bit          hold1 = 1'b0;
   logic [33:0] held0;
   logic [9:0]  held1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // plain integer arithmetic on the operands' values
   function automatic res_t model(input int w, input longint av,
                                  input longint bv, input bit cin,
                                  input bit su);
      res_t   e;
      longint half, sa, sbv, r, t;
      half = longint'(1) << (w - 1);
      sa   = (av >= half) ? av - 2 * half : av;
      sbv  = (bv >= half) ? bv - 2 * half : bv;
      if (!su) begin
         t   = av + bv + longint'(cin);
         e.c = (t >= 2 * half);
         r   = sa + sbv + longint'(cin);
      end else begin
         t   = av - bv - longint'(cin);
         e.c = (av >= bv + longint'(cin));
         r   = sa - sbv - longint'(cin);
      end
      e.s = 32'(t & (2 * half - 1));
      e.o = (r >= half) || (r < -half);
      return e;
   endfunction

   task automatic drive0(input bit v, input logic [31:0] av,
                         input logic [31:0] bv, input bit cin,
                         input bit su, input bit rdy, input res_t e,
                         output bit took);
      res_t ex;
      int   t;
      @(posedge clk);
      cyc++;
      #1;
      if (hold0) begin
         chk("hold_valid", ov, 1);
         chk("hold_data", {s, co, of}, held0);
      end
      iv = v; a = av; b = bv; ci = cin; sb = su; ordy = rdy;
      #1;
      if (ov && !rdy) chk("in_ready_stall", ir, 0);
      else chk("in_ready_open", ir, 1);
      if (ov && rdy) begin
         if (q0.size() == 0) chk("unexpected_out", ov, 0);
         else begin
            ex = q0.pop_front();
            t  = t0q.pop_front();
            chk("sum", s, ex.s);
            chk("c_out", co, ex.c);
            chk("ovf", of, ex.o);
            if (lat_on) chk("latency", cyc - t, 4);
         end
      end
      hold0 = ov && !rdy;
      held0 = {s, co, of};
      took  = v && ir;
      if (took) begin
         q0.push_back(e);
         t0q.push_back(cyc);
      end
   endtask

   task automatic drive1(input bit v, input logic [7:0] av,
                         input logic [7:0] bv, input bit cin,
                         input bit su, input bit rdy, input res_t e);
      res_t ex;
      int   t;
      @(posedge clk);
      cyc++;
      #1;
      if (hold1) begin
         chk("x_hold_valid", x_ov, 1);
         chk("x_hold_data", {x_s, x_co, x_of}, held1);
      end
      x_iv = v; x_a = av; x_b = bv; x_ci = cin; x_sb = su; x_ordy = rdy;
      #1;
      if (x_ov && !rdy) chk("x_in_ready_stall", x_ir, 0);
      else chk("x_in_ready_open", x_ir, 1);
      if (x_ov && rdy) begin
         if (q1.size() == 0) chk("x_unexpected_out", x_ov, 0);
         else begin
            ex = q1.pop_front();
            t  = t1q.pop_front();
            chk("x_sum", x_s, ex.s[7:0]);
            chk("x_c_out", x_co, ex.c);
            chk("x_ovf", x_of, ex.o);
            if (lat_on) chk("x_latency", cyc - t, 1);
         end
      end
      hold1 = x_ov && !rdy;
      held1 = {x_s, x_co, x_of};
      if (v && x_ir) begin
         q1.push_back(e);
         t1q.push_back(cyc);
      end
   endtask

   res_t        dir_e [5];
   logic [31:0] dir_a [5];
   logic [31:0] dir_b [5];
   bit          dir_c [5];
   bit          dir_s [5];

   initial begin
      bit          took;
      int          i;
      logic [31:0] ra, rb;
      bit          rc, rs, rv, rr;

      dir_a = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'd5, 32'd5};
      dir_b = '{32'h00000001, 32'h00000001, 32'h00000001, 32'd7, 32'd2};
      dir_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      dir_s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      dir_e[0] = '{s: 32'h00000000, c: 1'b1, o: 1'b0};
      dir_e[1] = '{s: 32'h80000000, c: 1'b0, o: 1'b1};
      dir_e[2] = '{s: 32'h7FFFFFFF, c: 1'b1, o: 1'b1};
      dir_e[3] = '{s: 32'hFFFFFFFE, c: 1'b0, o: 1'b0};
      dir_e[4] = '{s: 32'h00000002, c: 1'b1, o: 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", ov, 0);
      chk("rst_sum", s, 0);
      chk("rst_c_out", co, 0);
      chk("rst_ovf", of, 0);
      chk("x_rst_valid", x_ov, 0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", ir, 1);

      lat_on = 1'b1;
      for (int k = 0; k < 5; k++)
         drive0(1'b1, dir_a[k], dir_b[k], dir_c[k], dir_s[k], 1'b1,
                dir_e[k], took);
      for (int k = 0; k < 6; k++)
         drive0(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, dir_e[0], took);
      chk("dir_drain", q0.size(), 0);

      for (int k = 0; k < 8; k++) begin
         drive0(1'b1, 32'(k), 32'(k), 1'b0, 1'b0, 1'b1,
                '{s: 32'(2 * k), c: 1'b0, o: 1'b0}, took);
         chk("b2b_take", took, 1);
      end
      lat_on = 1'b0;

      i = 0;
      for (int k = 0; k < 100 && i < 12; k++) begin
         rr = !(k >= 6 && k < 9);
         drive0(1'b1, 32'(100 + i), 32'(i), 1'b0, 1'b0, rr,
                '{s: 32'(100 + 2 * i), c: 1'b0, o: 1'b0}, took);
         if (took) i++;
      end
      chk("stall_issue", i, 12);
      for (int k = 0; k < 8; k++)
         drive0(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, dir_e[0], took);
      chk("stall_drain", q0.size(), 0);

      for (int k = 0; k < 3; k++)
         drive0(1'b1, 32'hDEAD0000, 32'(k), 1'b0, 1'b0, 1'b1,
                dir_e[0], took);
      drive0(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, dir_e[0], took);
      rst = 1'b1;
      @(posedge clk);
      cyc++;
      #1;
      rst = 1'b0;
      q0.delete();
      t0q.delete();
      hold0 = 1'b0;
      chk("mid_rst_valid", ov, 0);
      chk("mid_rst_sum", s, 0);
      chk("mid_rst_c_out", co, 0);
      chk("mid_rst_ovf", of, 0);
      for (int k = 0; k < 8; k++)
         drive0(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, dir_e[0], took);
      lat_on = 1'b1;
      drive0(1'b1, 32'h12345678, 32'h11111111, 1'b1, 1'b1, 1'b1,
             '{s: 32'h01234566, c: 1'b1, o: 1'b0}, took);
      for (int k = 0; k < 6; k++)
         drive0(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, dir_e[0], took);
      chk("post_rst_drain", q0.size(), 0);
      lat_on = 1'b0;

      for (int k = 0; k < 3000; k++) begin
         ra = $urandom();
         rb = $urandom();
         if ($urandom_range(0, 7) == 0) ra = 32'h7FFFFFFF;
         if ($urandom_range(0, 7) == 0) rb = 32'h80000000;
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         rv = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 3) != 0);
         drive0(rv, ra, rb, rc, rs, rr,
                model(32, longint'(ra), longint'(rb), rc, rs), took);
      end
      for (int k = 0; k < 10; k++)
         drive0(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, dir_e[0], took);
      chk("rand_drain", q0.size(), 0);

      lat_on = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ra = $urandom();
         rb = $urandom();
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         drive1(1'b1, ra[7:0], rb[7:0], rc, rs, 1'b1,
                model(8, longint'(ra[7:0]), longint'(rb[7:0]), rc, rs));
      end
      drive1(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, dir_e[0]);
      lat_on = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         ra = $urandom();
         rb = $urandom();
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         rv = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 3) != 0);
         drive1(rv, ra[7:0], rb[7:0], rc, rs, rr,
                model(8, longint'(ra[7:0]), longint'(rb[7:0]), rc, rs));
      end
      for (int k = 0; k < 4; k++)
         drive1(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, dir_e[0]);
      chk("x_rand_drain", q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
